// File: rtl/decoder_seq.sv
// ---------------------------------------------------------------------------
// decoder_seq
//
// Registered 4-to-16 one-hot decoder with a valid/ready handshake and a
// programmable hold time. An accepted channel index drives exactly one bit
// of decoder_out for HOLD_CYCLES clocks. A single all-zero gap cycle follows,
// so consecutive selects can never overlap.
//
// Parameters
//   HOLD_CYCLES  clocks each select is held (legal 1..255, 8-bit counter)
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   enable       block enable; low aborts any operation, outputs go to zero
//   binary_in    4-bit channel index
//   in_valid     binary_in is valid
//   in_ready     index is accepted this cycle (combinational)
//   scan         request an automatic 0..15 sweep (DECODER_SCAN_EN only)
//   decoder_out  registered one-hot select, zero when idle or in a gap
//   busy         registered, high while driving or in a gap
//   done         registered one-cycle pulse at normal completion
//
// Configuration
//   DECODER_SCAN_EN  when defined, adds the SCAN_DRIVE/SCAN_GAP states and
//                    the sweep index counter. When undefined, the scan port
//                    is accepted but has no effect.
// ---------------------------------------------------------------------------
module decoder_seq #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  binary_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        scan,
  output logic [15:0] decoder_out,
  output logic        busy,
  output logic        done
);

  // The counter is loaded with HOLD_CYCLES-1 and counts down to zero. This
  // gives exactly HOLD_CYCLES cycles in a drive state.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 32'd1);

`ifdef DECODER_SCAN_EN
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRIVE      = 3'd1,
    ST_GAP        = 3'd2,
    ST_SCAN_DRIVE = 3'd3,
    ST_SCAN_GAP   = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;
`endif

  // One-hot decode of a 4-bit index.
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] out_q, out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept_s;
  logic        scan_block_s;

`ifdef DECODER_SCAN_EN
  logic [3:0]  idx_q, idx_d;

  // A pending scan request takes priority, so it withholds in_ready.
  assign scan_block_s = scan;
`else
  logic        unused_scan_s;

  assign unused_scan_s = scan;
  assign scan_block_s  = 1'b0;
`endif

  // Ready is decoded from state, enable and reset. Reset gates it so that
  // nothing is handshaken while the block is being cleared.
  assign in_ready = !reset && enable && (state_q == ST_IDLE) && !scan_block_s;
  assign accept_s = in_valid && in_ready;

  assign decoder_out = out_q;
  assign busy        = busy_q;
  assign done        = done_q;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
`ifdef DECODER_SCAN_EN
    idx_d   = idx_q;
`endif

    if (!enable) begin
      // An abort returns to IDLE silently. No done pulse is produced.
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
      out_d   = 16'h0000;
`ifdef DECODER_SCAN_EN
      idx_d   = 4'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_d = ST_DRIVE;
            cnt_d   = HOLD_LOAD;
            out_d   = onehot16(binary_in);
          end
`ifdef DECODER_SCAN_EN
          else if (scan) begin
            state_d = ST_SCAN_DRIVE;
            cnt_d   = HOLD_LOAD;
            idx_d   = 4'd0;
            out_d   = onehot16(4'd0);
          end
`endif
          else begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            out_d   = 16'h0000;
          end
        end

        ST_DRIVE: begin
          if (cnt_q == 8'd0) begin
            // Going into the gap: the select drops and done is raised so
            // that both appear together in the gap cycle.
            state_d = ST_GAP;
            out_d   = 16'h0000;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q - 8'd1;
          end
        end

        ST_GAP: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          out_d   = 16'h0000;
        end

`ifdef DECODER_SCAN_EN
        ST_SCAN_DRIVE: begin
          if (cnt_q == 8'd0) begin
            // Only the gap after index 15 ends the sweep. The done pulse
            // goes in that gap and nowhere else.
            state_d = ST_SCAN_GAP;
            out_d   = 16'h0000;
            done_d  = (idx_q == 4'd15);
          end else begin
            cnt_d   = cnt_q - 8'd1;
          end
        end

        ST_SCAN_GAP: begin
          if (idx_q == 4'd15) begin
            // No wrap. A new sweep needs scan to be asserted again.
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            idx_d   = 4'd0;
            out_d   = 16'h0000;
          end else begin
            state_d = ST_SCAN_DRIVE;
            cnt_d   = HOLD_LOAD;
            idx_d   = idx_q + 4'd1;
            out_d   = onehot16(idx_q + 4'd1);
          end
        end
`endif

        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          out_d   = 16'h0000;
        end
      endcase
    end

    // busy is registered alongside the state it describes.
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      out_q   <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DECODER_SCAN_EN
  // Sweep index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= 4'd0;
    end else begin
      idx_q <= idx_d;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// ---------------------------------------------------------------------------
// tb_decoder_seq
//
// Three decoder_seq instances (HOLD_CYCLES = 4, 1, 2) share one stimulus
// stream. A timeline model tracks each instance: it holds an active flag and
// the number of cycles since acceptance. From that count it computes what
// every output must be. Directed scenarios pin the model with literal
// values, and a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_decoder_seq;

  localparam int NI = 3;

`ifdef DECODER_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  function automatic int hold_of(input int k);
    hold_of = (k == 0) ? 4 : ((k == 1) ? 1 : 2);
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic        scan;
  logic [3:0]  binary_in;
  logic [15:0] dout [NI];
  logic        rdy  [NI];
  logic        bsy  [NI];
  logic        dn   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned H_G = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
    decoder_seq #(.HOLD_CYCLES(H_G)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .binary_in  (binary_in),
      .in_valid   (in_valid),
      .in_ready   (rdy[g]),
      .scan       (scan),
      .decoder_out(dout[g]),
      .busy       (bsy[g]),
      .done       (dn[g])
    );
  end

  // ---------------- behavioural model ----------------
  bit act   [NI];   // an operation is in progress
  int tt    [NI];   // cycles since the accept edge (0 = first drive cycle)
  int midx  [NI];
  bit mscan [NI];
  bit acc   [NI];   // accepted at the most recent edge

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  function automatic int op_len(input int k);
    op_len = mscan[k] ? 16 * (hold_of(k) + 1) : hold_of(k) + 1;
  endfunction

  function automatic logic [15:0] e_out(input int k);
    int h;
    h = hold_of(k);
    if (!act[k]) e_out = 16'h0000;
    else if (mscan[k]) e_out = ((tt[k] % (h + 1)) < h) ? (16'h0001 << (tt[k] / (h + 1))) : 16'h0000;
    else e_out = (tt[k] < h) ? (16'h0001 << midx[k]) : 16'h0000;
  endfunction

  function automatic logic e_done(input int k);
    int h;
    h = hold_of(k);
    if (!act[k]) e_done = 1'b0;
    else if (mscan[k]) e_done = (tt[k] == 16 * (h + 1) - 1);
    else e_done = (tt[k] == h);
  endfunction

  function automatic logic e_rdy(input int k);
    e_rdy = !act[k] && enable && !reset && !(SCAN_ON && scan);
  endfunction

  task automatic cmp(input string nm, input int k, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d: got %h, want %h", nm, k, cyc, got, exp);
    end
  endtask

  // One clock: the model advances with the inputs the DUT samples at this edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      acc[k] = 1'b0;
      if (reset || !enable) begin
        act[k] = 1'b0;
      end else if (act[k]) begin
        tt[k]++;
        if (tt[k] >= op_len(k)) act[k] = 1'b0;
      end else if ((SCAN_ON && scan) || in_valid) begin
        act[k]   = 1'b1;
        acc[k]   = 1'b1;
        tt[k]    = 0;
        mscan[k] = SCAN_ON && scan;
        midx[k]  = int'(binary_in);
      end
    end
    cyc++;
    #1;
  endtask

  // Every-cycle comparison against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int k = 0; k < NI; k++) begin
          cmp("decoder_out", k, dout[k], e_out(k));
          cmp("busy", k, 16'(bsy[k]), 16'(act[k]));
          cmp("done", k, 16'(dn[k]), 16'(e_done(k)));
          cmp("in_ready", k, 16'(rdy[k]), 16'(e_rdy(k)));
          checks++;
          if ($countones(dout[k]) > 1) begin
            errors++;
            $display("FAIL onehot[%0d] cycle %0d: got %h, want at most one bit", k, cyc, dout[k]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int nb;
    int nd;
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; scan = 1'b0; binary_in = 4'd0;
    for (int k = 0; k < NI; k++) begin
      act[k] = 1'b0; tt[k] = 0; midx[k] = 0; mscan[k] = 1'b0; acc[k] = 1'b0;
    end
    repeat (2) tick();
    chk_on = 1'b1;

    // Reset values
    cmp("rst_out", 0, dout[0], 16'h0000);
    cmp("rst_rdy", 0, 16'(rdy[0]), 16'd0);
    cmp("rst_busy", 0, 16'(bsy[0]), 16'd0);

    // Index 5 with HOLD 4
    reset = 1'b0; enable = 1'b1;
    #1 cmp("idle_rdy", 0, 16'(rdy[0]), 16'd1);
    binary_in = 4'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cmp("t1_out", j, dout[0], 16'h0020);
      cmp("t1_busy", j, 16'(bsy[0]), 16'd1);
      if (j < 3) tick();
    end
    tick();
    cmp("t1_gap_out", 0, dout[0], 16'h0000);
    cmp("t1_gap_done", 0, 16'(dn[0]), 16'd1);
    cmp("t1_gap_rdy", 0, 16'(rdy[0]), 16'd0);
    tick();
    cmp("t1_ready_again", 0, 16'(rdy[0]), 16'd1);
    cmp("t1_done_clear", 0, 16'(dn[0]), 16'd0);

    // Sweep 0..15 with in_valid held high
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      binary_in = 4'(i);
      n = 0;
      do begin
        tick();
        n++;
      end while (!acc[0] && n < 20);
      cmp("sweep_out", i, dout[0], 16'h0001 << i);
      cmp("sweep_spacing", i, 16'(n), (i == 0) ? 16'd1 : 16'd6);
    end
    in_valid = 1'b0;
    repeat (8) tick();

    // HOLD 1, index 15
    binary_in = 4'd15; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cmp("h1_out", 1, dout[1], 16'h8000);
    tick();
    cmp("h1_gap_out", 1, dout[1], 16'h0000);
    cmp("h1_gap_done", 1, 16'(dn[1]), 16'd1);
    cmp("h4_still", 0, dout[0], 16'h8000);
    tick();
    cmp("h1_rdy", 1, 16'(rdy[1]), 16'd1);
    repeat (6) tick();

    // Enable drop on the second drive cycle
    binary_in = 4'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    cmp("en_drive2", 0, dout[0], 16'h0008);
    enable = 1'b0;
    #1 cmp("en_rdy_low", 0, 16'(rdy[0]), 16'd0);
    tick();
    cmp("en_out", 0, dout[0], 16'h0000);
    cmp("en_busy", 0, 16'(bsy[0]), 16'd0);
    cmp("en_done", 0, 16'(dn[0]), 16'd0);
    enable = 1'b1; binary_in = 4'd9; in_valid = 1'b1;
    #1 cmp("en_rdy_back", 0, 16'(rdy[0]), 16'd1);
    tick();
    in_valid = 1'b0;
    cmp("en_out9", 0, dout[0], 16'h0200);
    repeat (6) tick();

    // Reset during drive of index 7
    binary_in = 4'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1 cmp("mr_rdy", 0, 16'(rdy[0]), 16'd0);
    tick();
    cmp("mr_out", 0, dout[0], 16'h0000);
    cmp("mr_busy", 0, 16'(bsy[0]), 16'd0);
    cmp("mr_done", 0, 16'(dn[0]), 16'd0);
    reset = 1'b0;
    #1 cmp("mr_rdy_back", 0, 16'(rdy[0]), 16'd1);
    tick();

`ifdef DECODER_SCAN_EN
    // Scan sweep on the HOLD 2 instance; scan is pulsed for one cycle only
    scan = 1'b1;
    tick();
    scan = 1'b0;
    cmp("scan_first", 2, dout[2], 16'h0001);
    nb = 0; nd = 0; n = 0;
    do begin
      if (bsy[2]) nb++;
      if (dn[2]) nd++;
      tick();
      n++;
    end while (bsy[2] && n < 100);
    cmp("scan_cycles", 2, 16'(nb), 16'd48);
    cmp("scan_dones", 2, 16'(nd), 16'd1);
    repeat (90) tick();
`endif

    // Randomized phase
    for (int r = 0; r < 600; r++) begin
      reset     = ($urandom_range(0, 63) == 0);
      enable    = ($urandom_range(0, 15) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      binary_in = 4'($urandom_range(0, 15));
      scan      = ($urandom_range(0, 31) == 0);
      tick();
    end
    reset = 1'b0; enable = 1'b1; in_valid = 1'b0; scan = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
# decoder_seq

Registered 4-to-16 one-hot decoder with a valid/ready handshake and a programmable hold time. It takes a 4-bit channel index, drives exactly one bit of a 16-bit select bus for HOLD_CYCLES clocks, and then inserts a one-cycle all-zero gap so that consecutive selects never overlap. It sits on the far side of the one-hot-to-binary encoder: it regenerates one-hot selects from binary indices, for chip-select and row-strobe style loads.

## Interface
- HOLD_CYCLES, 4, number of clocks each one-hot select is held; legal range 1..255; counter is 8 bits.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  block enable; low aborts any operation and forces outputs to zero.
- binary_in  input  4  channel index to decode.
- in_valid  input  1  binary_in is valid.
- in_ready  output  1  block accepts an index this cycle.
- scan  input  1  request an automatic sweep of channels 0..15; active only with DECODER_SCAN_EN.
- decoder_out  output  16  registered one-hot select; all zero when idle.
- busy  output  1  high in DRIVE or GAP.
- done  output  1  one-cycle pulse when a select (or a full sweep) completes normally.

## Operation
- States: IDLE, DRIVE, GAP (SCAN_DRIVE and SCAN_GAP when scan is compiled in).
- IDLE: decoder_out = 0, busy = 0, in_ready = enable.
- Accept: in_valid && in_ready at a rising edge.
  - Next state is DRIVE.
  - decoder_out = 16'h0001 << binary_in (index 0 → 16'h0001, index 15 → 16'h8000).
  - hold counter = HOLD_CYCLES-1.
- DRIVE: decoder_out holds its value; the counter decrements each cycle. When the counter is 0, go to GAP.
- GAP: decoder_out = 0 for exactly one cycle, done = 1 for that cycle, then IDLE.
- binary_in and in_valid are ignored outside IDLE, and in_ready = 0 there. Back-to-back requests are therefore spaced HOLD_CYCLES+2 cycles apart: HOLD_CYCLES drive cycles, one GAP cycle, and one IDLE cycle in which the next request is accepted.
- Invariant: popcount(decoder_out) ≤ 1 on every cycle.
- enable low in any state:
  - next edge: decoder_out = 0, state = IDLE, counter = 0, no done pulse.
  - in_ready is low combinationally while enable is low.
- Simultaneous accept and enable fall: cannot occur, because in_ready already requires enable.

## Timing
- Reset values: decoder_out = 16'h0000, busy = 0, done = 0, in_ready = 0 during reset (reset gates in_ready), state = IDLE, counter = 0.
- Reset mid-operation: outputs are zero at the edge where reset is sampled; no done pulse.
- Accept at edge N:
  - decoder_out valid and busy = 1 from edge N+1 through edge N+HOLD_CYCLES.
  - GAP and done = 1 in cycle N+HOLD_CYCLES+1.
  - in_ready high again from cycle N+HOLD_CYCLES+2.
- All outputs are registered except in_ready, which is decoded from state, enable and reset.

## Configuration
- Macro: DECODER_SCAN_EN.
- Defined:
  - In IDLE with enable && scan, the block enters SCAN_DRIVE at index 0. scan takes priority over in_valid in the same cycle, and in_ready = 0 while scan is high.
  - Each index is driven for HOLD_CYCLES, followed by a one-cycle zero gap.
  - The index increments 0→15. After the index-15 gap, done pulses once and the block returns to IDLE. There is no wrap, and scan must be re-asserted for a new sweep.
  - Deasserting scan mid-sweep has no effect. Only enable or reset aborts a sweep.
- Undefined: the scan port exists but is ignored, the scan states and index counter are not synthesized, and behaviour is as above without scan.

## Test plan
- Reset, then HOLD_CYCLES=4, accept binary_in=4'd5 → decoder_out=16'h0020 for 4 cycles, 1 zero cycle with done=1, in_ready high 6 cycles after the accept edge.
- Sweep all indices 0..15 with in_valid held high → each produces 16'h0001<<i, one-hot every cycle, with a zero gap between consecutive selects.
- HOLD_CYCLES=1, accept 4'd15 → 16'h8000 for exactly 1 cycle, then GAP with done=1.
- Accept 4'd3, drop enable on the 2nd DRIVE cycle → decoder_out=0 and IDLE next edge, no done; request 4'd9 accepted after enable returns → 16'h0200.
- Assert reset during DRIVE of 4'd7 → decoder_out=0, busy=0, done=0 at the next edge; in_ready returns 1 when reset releases.
- DECODER_SCAN_EN, HOLD_CYCLES=2, pulse scan → 16'h0001..16'h8000 in order, 48 cycles total, a single done pulse; scan deasserted mid-sweep does not stop it.
